seconds_units_stage: RTL
========================

SECONDS_UNITS_STAGE -- requirements
Module: seconds_units_stage

Interface
REQ-001 The block SHALL have parameter DIVISOR, default 50000000, giving Clock cycles per one-second Tick (minimum 2).
REQ-002 The block SHALL have parameter DEBOUNCE, default 500000, giving consecutive stable cycles required to accept a HoldBtn level change (minimum 1).
REQ-003 The block SHALL have port Clock, input, 1, the single system clock; all state updates on its rising edge.
REQ-004 The block SHALL have port Reset, input, 1, a synchronous active-high reset.
REQ-005 The block SHALL have port Direction, input, 1, asynchronous count direction: 0 = up, 1 = down.
REQ-006 The block SHALL have port HoldBtn, input, 1, a raw asynchronous pushbutton (1 = pressed) that toggles run/pause.
REQ-007 The block SHALL have port Units, output, 4, the seconds-units digit in BCD, range 0-9.
REQ-008 The block SHALL have port Carry, output, 1, a one-cycle pulse on a units wrap, feeding the downstream tens-digit stage.
REQ-009 The block SHALL have port Tick, output, 1, a one-cycle pulse marking each counted second.
REQ-010 The block SHALL have port Hold, output, 1, the current pause state: 1 = paused.

Function
REQ-011 Direction and HoldBtn SHALL each pass through a two-flop synchronizer before use, adding 2 cycles of latency.
REQ-012 The prescaler SHALL count 0..DIVISOR-1 and wrap to 0; it advances only while Hold=0 and otherwise retains its value.
REQ-013 Tick SHALL be registered and SHALL be 1 for exactly the cycle after the prescaler reaches DIVISOR-1 with Hold=0; otherwise it is 0.
REQ-014 On a tick event with synchronized Direction=0: Units<9 gives Units+1 with Carry=0; Units=9 gives Units=0 with Carry=1.
REQ-015 On a tick event with synchronized Direction=1: Units>0 gives Units-1 with Carry=0; Units=0 gives Units=9 with Carry=1.
REQ-016 Units, Carry and Tick SHALL update on the same clock edge, so Carry coincides with the wrapped Units value.
REQ-017 Carry SHALL be 0 in every cycle without a tick event; Carry is never asserted on two consecutive cycles.
REQ-018 An illegal Units value (10-15) on a tick event SHALL load 0 with Carry=0.
REQ-019 A Direction change SHALL take effect at the next tick event only; it does not reset the prescaler.
REQ-020 Debouncer: the debounced level SHALL take the synchronized HoldBtn value after that value has differed from the debounced level for DEBOUNCE consecutive cycles; any cycle of agreement clears the stability counter.
REQ-021 Hold SHALL toggle exactly once, one cycle after the debounced level goes 0->1; a debounced 1->0 transition has no effect.
REQ-022 Tick generation SHALL use the registered Hold value of the current cycle, so a toggle landing on the prescaler's terminal cycle still lets that tick complete.
REQ-023 While Hold=1, Units SHALL be frozen and Tick and Carry SHALL both be 0.

Reset
REQ-024 On any cycle with Reset=1, the block SHALL set Units=9, Carry=0, Tick=0, Hold=1, prescaler=0, stability counter=0, debounced level=0 and all synchronizer flops=0.
REQ-025 Reset SHALL take priority over all other events, including an in-progress tick or debounce, and no partial state SHALL survive it.

Verification (DIVISOR=4, DEBOUNCE=3)
REQ-026 The bench SHALL check reset: assert Reset for 2 cycles, then release -> Units=9, Hold=1, Tick=0, Carry=0, with Units still 9 after 20 cycles.
REQ-027 The bench SHALL check run-up: press HoldBtn for 10 cycles with Direction=0 -> Hold becomes 0 once, Tick pulses every 4 cycles, the first tick gives Units=0 with Carry=1, and the next ticks give 1, 2, ... with Carry=0.
REQ-028 The bench SHALL check run-down: with Direction=1 and Units=1 -> the next ticks give 0 (Carry=0), then 9 (Carry=1), then 8.
REQ-029 The bench SHALL check debounce: HoldBtn glitches of 1-2 cycles -> no Hold change; a press held for 6 or more cycles -> exactly one toggle; a release followed by a new press -> a second toggle.
REQ-030 The bench SHALL check pause: set Hold=1 mid-period -> Units frozen and no Tick or Carry; clear Hold -> ticks resume with the prescaler continuing from its retained value.
REQ-031 The bench SHALL check mid-operation reset: assert Reset in the same cycle as the prescaler's terminal count with Units=9 and Direction=0 -> no Carry, Units=9, Hold=1 on the next cycle.

Source files
------------

// File: rtl/seconds_units_stage.sv
// Seconds-units BCD digit with a prescaled one-second tick, up/down direction,
// and a debounced pushbutton that toggles run/pause. Carry feeds the tens stage.
module seconds_units_stage #(
  parameter int unsigned DIVISOR  = 50000000,
  parameter int unsigned DEBOUNCE = 500000
) (
  input  logic       Clock,
  input  logic       Reset,
  input  logic       Direction,
  input  logic       HoldBtn,
  output logic [3:0] Units,
  output logic       Carry,
  output logic       Tick,
  output logic       Hold
);

  localparam int unsigned PW = $clog2(DIVISOR);
  localparam int unsigned DW = $clog2(DEBOUNCE + 1);
  localparam logic [PW-1:0] PRE_LAST = PW'(DIVISOR - 1);
  localparam logic [DW-1:0] DB_LAST  = DW'(DEBOUNCE - 1);

  logic          dir_s1, dir_s2;
  logic          btn_s1, btn_s2;
  logic [DW-1:0] db_cnt;
  logic          db_level;
  logic          db_prev;
  logic [PW-1:0] prescale;
  logic          tick_ev;

  always_ff @(posedge Clock) begin
    if (Reset) begin
      dir_s1 <= 1'b0;
      dir_s2 <= 1'b0;
      btn_s1 <= 1'b0;
      btn_s2 <= 1'b0;
    end else begin
      dir_s1 <= Direction;
      dir_s2 <= dir_s1;
      btn_s1 <= HoldBtn;
      btn_s2 <= btn_s1;
    end
  end

  // Level is accepted only after DEBOUNCE consecutive disagreeing cycles.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      db_cnt   <= '0;
      db_level <= 1'b0;
      db_prev  <= 1'b0;
      Hold     <= 1'b1;
    end else begin
      if (btn_s2 != db_level) begin
        if (db_cnt == DB_LAST) begin
          db_level <= btn_s2;
          db_cnt   <= '0;
        end else begin
          db_cnt <= db_cnt + DW'(1);
        end
      end else begin
        db_cnt <= '0;
      end
      db_prev <= db_level;
      if (db_level && !db_prev)
        Hold <= ~Hold;
    end
  end

  always_comb begin
    tick_ev = !Hold && (prescale == PRE_LAST);
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      prescale <= '0;
      Tick     <= 1'b0;
    end else begin
      Tick <= tick_ev;
      if (!Hold)
        prescale <= (prescale == PRE_LAST) ? '0 : prescale + PW'(1);
    end
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      Units <= 4'd9;
      Carry <= 1'b0;
    end else begin
      Carry <= 1'b0;
      if (tick_ev) begin
        if (Units > 4'd9) begin
          Units <= '0;
        end else if (!dir_s2) begin
          if (Units == 4'd9) begin
            Units <= '0;
            Carry <= 1'b1;
          end else begin
            Units <= Units + 4'd1;
          end
        end else begin
          if (Units == 4'd0) begin
            Units <= 4'd9;
            Carry <= 1'b1;
          end else begin
            Units <= Units - 4'd1;
          end
        end
      end
    end
  end

endmodule
